multi_button_debouncer: RTL and testbench
=========================================

MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent button channels (>=1).
REQ-002 Parameter STABLE_CYCLES, default 3: consecutive synchronised samples needed to accept a level change (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50: cycles from press pulse to first repeat pulse (>=1).
REQ-004 Parameter REPEAT_CYCLES, default 10: cycles between later repeat pulses (>=1).
REQ-005 Parameter REPEAT_EN, default 1: 1 enables auto-repeat; 0 holds repeat_pulse at 0.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 buttons_in  input  CHANNELS  raw asynchronous button levels, 1 = pressed.
REQ-009 level_out  output  CHANNELS  debounced level per channel.
REQ-010 press_pulse  output  CHANNELS  one-cycle pulse on a debounced 0->1 transition.
REQ-011 release_pulse  output  CHANNELS  one-cycle pulse on a debounced 1->0 transition.
REQ-012 repeat_pulse  output  CHANNELS  one-cycle auto-repeat pulse while a channel is held.
REQ-013 any_pressed  output  1  OR of all level_out bits, registered together with level_out.

Function
REQ-014 Each channel SHALL pass buttons_in[i] through two flip-flops (sync1, sync2) before any other use.
REQ-015 Each channel SHALL keep a stability counter, ceil(log2(STABLE_CYCLES+1)) bits wide, that counts only while sync2 differs from level_out.
REQ-016 Stability counter rules: sync2 == level_out -> counter = 0. Mismatch with counter == STABLE_CYCLES-1 -> level_out toggles and counter = 0. Otherwise -> counter + 1.
REQ-017 Latency: a raw level that is stable from edge k SHALL change level_out at edge k+1+STABLE_CYCLES (k+4 at the default).
REQ-018 A bounce, meaning sync2 returning to level_out before the count completes, SHALL clear the counter with no output change.
REQ-019 press_pulse[i] SHALL be 1 for exactly the one cycle that starts at the edge where level_out[i] rises; release_pulse[i] likewise for a fall.
REQ-020 Each channel SHALL run a 3-state FSM: IDLE, HOLD, REPEAT.
REQ-021 FSM transitions: IDLE->HOLD on a rise; HOLD->REPEAT when the hold counter reaches HOLD_CYCLES; any state->IDLE on a fall.
REQ-022 The hold/repeat counter SHALL clear on entry to HOLD and to REPEAT and increment each cycle in those states; its width SHALL hold max(HOLD_CYCLES, REPEAT_CYCLES).
REQ-023 repeat_pulse[i] SHALL fire for one cycle when HOLD reaches HOLD_CYCLES, and then each time REPEAT reaches REPEAT_CYCLES (counter clears and continues).
REQ-024 First repeat SHALL occur HOLD_CYCLES cycles after press_pulse; later repeats every REPEAT_CYCLES cycles.
REQ-025 A fall in the same cycle a repeat would fire SHALL give release_pulse only; no repeat_pulse.
REQ-026 With REPEAT_EN = 0, repeat_pulse SHALL stay 0; the FSM and counters still run.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-028 press_pulse, release_pulse and repeat_pulse SHALL never be high together on one channel.

Reset
REQ-029 While rst_n is 0 at a clk edge, the block SHALL clear sync1, sync2, level_out, all counters, all pulses and any_pressed to 0, and set every FSM to IDLE.
REQ-030 Reset asserted mid-count or mid-hold SHALL abort the operation with no pulse. After release, a button still held SHALL be re-detected as a fresh press after the normal latency.

Verification (CHANNELS=2, STABLE_CYCLES=3, HOLD_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1)
REQ-031 buttons_in[0] 0->1 at edge 10, held -> level_out[0]=1 from edge 14; press_pulse[0] high in cycle 14 only.
REQ-032 buttons_in[0] pulses 1 for 2 cycles then 0, repeated 5 times -> level_out stays 0; no pulses.
REQ-033 Channel 0 held 30 cycles after press at edge 14 -> repeat_pulse[0] at edges 22, 26, 30, 34, 38, 42.
REQ-034 Both channels rise at the same edge -> both press_pulse bits high in the same cycle; any_pressed=1 in that cycle.
REQ-035 rst_n=0 for one cycle at edge 20 during a hold -> all outputs 0 at edge 20; with the button held, press_pulse returns at edge 25.
REQ-036 Release timed so the fall lands on a would-be repeat edge -> release_pulse=1 and repeat_pulse=0 in that cycle.

Source files
------------

// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: per-channel 2FF sync, stability debounce, press/release/auto-repeat pulses.
// Ports: clk, rst_n (sync, active-low), buttons_in -> level_out, press/release/repeat_pulse, any_pressed.
module multi_button_debouncer #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] buttons_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_pressed
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int MC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                      HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(MC + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } state_t;

  logic [CHANNELS-1:0] lvl_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          s1, s2, lvl;
    logic          lvl_d;
    logic [SW-1:0] stab_q, stab_d;
    state_t        st_q, st_d;
    logic [HW-1:0] hc_q, hc_d;
    logic          rise, fall;
    logic          prs_q, rel_q, rpt_q;
    logic          rpt_d;

    // Count consecutive mismatches; the last one flips the level.
    always_comb begin
      stab_d = '0;
      lvl_d  = lvl;
      if (s2 != lvl) begin
        if (stab_q == STAB_LAST) begin
          lvl_d = ~lvl;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
    end

    assign rise       = lvl_d & ~lvl;
    assign fall       = ~lvl_d & lvl;
    assign lvl_nxt[i] = lvl_d;

    always_comb begin
      st_d = st_q;
      hc_d = hc_q;
      unique case (st_q)
        IDLE: begin
          hc_d = '0;
          if (rise) st_d = HOLD;
        end
        HOLD: begin
          if (fall) begin
            st_d = IDLE;
            hc_d = '0;
          end else if (hc_q == HOLD_LAST) begin
            st_d = RPT;
            hc_d = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        RPT: begin
          if (fall) begin
            st_d = IDLE;
            hc_d = '0;
          end else if (hc_q == RPT_LAST) begin
            hc_d = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        default: begin
          st_d = IDLE;
          hc_d = '0;
        end
      endcase
    end

    // A fall wins over a repeat due in the same cycle.
    always_comb begin
      rpt_d = 1'b0;
      if (REPEAT_EN && !fall) begin
        unique case (1'b1)
          (st_q == HOLD): rpt_d = (hc_q == HOLD_LAST);
          (st_q == RPT):  rpt_d = (hc_q == RPT_LAST);
          default:        rpt_d = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        lvl    <= 1'b0;
        stab_q <= '0;
        st_q   <= IDLE;
        hc_q   <= '0;
        prs_q  <= 1'b0;
        rel_q  <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        s1     <= buttons_in[i];
        s2     <= s1;
        lvl    <= lvl_d;
        stab_q <= stab_d;
        st_q   <= st_d;
        hc_q   <= hc_d;
        prs_q  <= rise;
        rel_q  <= fall;
        rpt_q  <= rpt_d;
      end
    end

    assign level_out[i]     = lvl;
    assign press_pulse[i]   = prs_q;
    assign release_pulse[i] = rel_q;
    assign repeat_pulse[i]  = rpt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_pressed <= 1'b0;
    end else begin
      any_pressed <= |lvl_nxt;
    end
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb_multi_button_debouncer: directed and random checks against a behavioural model.
// Drives CHANNELS=2, STABLE=3, HOLD=8, REPEAT=4.
module tb_multi_button_debouncer;
  localparam int CH = 2;
  localparam int S  = 3;
  localparam int H  = 8;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] buttons_in = '0;
  logic [CH-1:0] level_out, press_pulse, release_pulse, repeat_pulse;
  logic          any_pressed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  logic [CH-1:0] m_pr = '0, m_rl = '0, m_rp = '0;
  logic          m_any = 1'b0;
  int            m_run [CH];
  int            m_pt  [CH];

  always #5 clk = ~clk;

  multi_button_debouncer #(
    .CHANNELS(CH), .STABLE_CYCLES(S), .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons_in(buttons_in),
    .level_out(level_out), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .any_pressed(any_pressed)
  );

  wire [4*CH:0] got = {level_out, press_pulse, release_pulse,
                       repeat_pulse, any_pressed};

  function automatic logic [4*CH:0] mexp();
    return {m_lvl, m_pr, m_rl, m_rp, m_any};
  endfunction

  // Model: level flips after S consecutive synced mismatches;
  // repeats fire at press age H, H+R, H+2R ... while held.
  task automatic tick(input logic [CH-1:0] b, input logic r);
    logic nl;
    int   age;
    buttons_in = b;
    rst_n      = r;
    @(posedge clk);
    cyc++;
    if (!r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_pr = '0; m_rl = '0; m_rp = '0; m_any = 1'b0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        nl = m_lvl[i];
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == S) begin
            nl = ~nl;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_pr[i] = nl & ~m_lvl[i];
        m_rl[i] = ~nl & m_lvl[i];
        if (m_pr[i]) m_pt[i] = cyc;
        age = cyc - m_pt[i];
        m_rp[i] = nl && m_lvl[i] && age >= H && ((age - H) % R) == 0;
        m_lvl[i] = nl;
      end
      m_s2  = m_s1;
      m_s1  = b;
      m_any = |m_lvl;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int j = 0; j < 3; j++) begin
      tick('1, 1'b0);
      total++;
      if (got !== '0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b want=0", cyc, got);
      end
    end
    for (int j = 0; j < 6; j++) tick('0, 1'b1);
  endtask

  task automatic test_press();
    int k;
    tick(2'b01, 1'b1);
    k = cyc;
    for (int j = 0; j < 8; j++) begin
      tick(2'b01, 1'b1);
      total++;
      if (press_pulse[0] !== (cyc == k + 4) ||
          level_out[0] !== (cyc >= k + 4)) begin
        bad++;
        $display("FAIL press_lat cyc=%0d k=%0d got=%b/%b", cyc, k,
                 press_pulse[0], level_out[0]);
      end
      total++;
      if (got !== mexp()) begin
        bad++;
        $display("FAIL press_model cyc=%0d got=%b want=%b", cyc, got, mexp());
      end
    end
    for (int j = 0; j < 8; j++) tick('0, 1'b1);
  endtask

  task automatic test_bounce();
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 4; j++) begin
        tick((j < 2) ? 2'b01 : 2'b00, 1'b1);
        total++;
        if ({level_out, press_pulse, release_pulse, repeat_pulse} !== '0) begin
          bad++;
          $display("FAIL bounce cyc=%0d got=%b want=0", cyc, got);
        end
      end
    end
    for (int j = 0; j < 4; j++) tick('0, 1'b1);
  endtask

  task automatic test_repeat();
    int p;
    tick(2'b01, 1'b1);
    p = cyc + 4;
    for (int j = 0; j < 38; j++) begin
      tick(2'b01, 1'b1);
      if (cyc > p) begin
        total++;
        if (repeat_pulse[0] !== (cyc >= p + H && ((cyc - p - H) % R) == 0)) begin
          bad++;
          $display("FAIL repeat_at cyc=%0d p=%0d got=%b", cyc, p, repeat_pulse[0]);
        end
      end
      total++;
      if (got !== mexp()) begin
        bad++;
        $display("FAIL repeat_model cyc=%0d got=%b want=%b", cyc, got, mexp());
      end
    end
    for (int j = 0; j < 8; j++) tick('0, 1'b1);
  endtask

  task automatic test_simultaneous();
    int k;
    tick(2'b11, 1'b1);
    k = cyc;
    for (int j = 0; j < 6; j++) begin
      tick(2'b11, 1'b1);
      if (cyc == k + 4) begin
        total++;
        if (press_pulse !== 2'b11 || any_pressed !== 1'b1) begin
          bad++;
          $display("FAIL simul cyc=%0d got=%b/%b want=11/1", cyc,
                   press_pulse, any_pressed);
        end
      end
    end
    for (int j = 0; j < 8; j++) begin
      tick('0, 1'b1);
      total++;
      if (got !== mexp()) begin
        bad++;
        $display("FAIL simul_model cyc=%0d got=%b want=%b", cyc, got, mexp());
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int e;
    for (int j = 0; j < 10; j++) tick(2'b01, 1'b1);
    tick(2'b01, 1'b0);
    e = cyc;
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL rst_hold cyc=%0d got=%b want=0", cyc, got);
    end
    for (int j = 0; j < 8; j++) begin
      tick(2'b01, 1'b1);
      total++;
      if (press_pulse[0] !== (cyc == e + 5) || repeat_pulse[0] !== 1'b0) begin
        bad++;
        $display("FAIL rst_repress cyc=%0d e=%0d got=%b/%b", cyc, e,
                 press_pulse[0], repeat_pulse[0]);
      end
    end
    for (int j = 0; j < 8; j++) tick('0, 1'b1);
  endtask

  task automatic test_release_on_repeat();
    int p;
    tick(2'b01, 1'b1);
    p = cyc + 4;
    while (cyc < p + 7) tick(2'b01, 1'b1);
    for (int j = 0; j < 8; j++) begin
      tick(2'b00, 1'b1);
      if (cyc == p + 12) begin
        total++;
        if (release_pulse[0] !== 1'b1 || repeat_pulse[0] !== 1'b0) begin
          bad++;
          $display("FAIL rel_on_rpt cyc=%0d got=%b/%b want=1/0", cyc,
                   release_pulse[0], repeat_pulse[0]);
        end
      end
      total++;
      if (got !== mexp()) begin
        bad++;
        $display("FAIL rel_model cyc=%0d got=%b want=%b", cyc, got, mexp());
      end
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] b = '0;
    logic          r;
    for (int j = 0; j < 600; j++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
      r = ($urandom_range(0, 149) != 0);
      tick(b, r);
      total++;
      if (got !== mexp()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, got, mexp());
      end
      total++;
      if ((press_pulse & release_pulse) !== '0 ||
          (press_pulse & repeat_pulse) !== '0 ||
          (release_pulse & repeat_pulse) !== '0) begin
        bad++;
        $display("FAIL exclusive cyc=%0d got=%b/%b/%b", cyc,
                 press_pulse, release_pulse, repeat_pulse);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0;
      m_pt[i]  = 0;
    end
    test_reset();
    test_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_release_on_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
